button_gesture_ctrl: RTL and testbench

Single-button user-interface controller for the 1 kHz board clock domain. It synchronises and debounces the raw push-button, classifies each gesture as a short press, double click or long press, and sequences a 4-mode LED state machine (OFF, ON, SLOW blink, FAST blink) from those gestures. The gesture event pulses and the current mode are exported so other blocks can reuse them.

---
 rtl/gesture_pkg.sv | 50 +++++
 rtl/btn_debounce.sv | 53 +++++
 rtl/button_gesture_ctrl.sv | 173 +++++++++++++++++
 tb/tb_button_gesture_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gesture_pkg.sv
// Shared definitions for the single-button gesture controller:
// mode and FSM encodings, default timing constants (1 cycle = 1 ms),
// and small helpers for counter sizing and mode sequencing.
package gesture_pkg;

  localparam int unsigned DEF_DEBOUNCE_MS   = 20;
  localparam int unsigned DEF_LONG_MS       = 1000;
  localparam int unsigned DEF_DOUBLE_GAP_MS = 300;
  localparam int unsigned DEF_SLOW_HALF_MS  = 500;
  localparam int unsigned DEF_FAST_HALF_MS  = 125;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_ON   = 2'd1,
    MODE_SLOW = 2'd2,
    MODE_FAST = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_WAIT2  = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_HELD   = 3'd4
  } state_t;

  // Bits needed for a counter running 0 .. n-1 (at least one bit).
  function automatic int unsigned cnt_width(int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Mode transition for one classified gesture; long press dominates.
  function automatic mode_t next_mode(mode_t cur, logic evt_short,
                                      logic evt_double, logic evt_long);
    mode_t nxt;
    nxt = cur;
    if (evt_long)
      nxt = MODE_OFF;
    else if (evt_double)
      nxt = (cur == MODE_SLOW) ? MODE_FAST : MODE_SLOW;
    else if (evt_short)
      nxt = (cur == MODE_OFF) ? MODE_ON : MODE_OFF;
    return nxt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button input conditioning: 2-flop synchroniser, debounce counter
// and one-cycle edge strobes on the debounced level.
// Ports: CLK, RST (sync, active high), BTN (raw) -> DB (debounced level),
//        RISE / FALL (registered one-cycle strobes, coincident with DB change).
module btn_debounce
  import gesture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  output logic DB,
  output logic RISE,
  output logic FALL
);

  localparam int unsigned DB_W = cnt_width(DEBOUNCE_MS);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_MS - 1);

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] cnt;

  // Accept the synchronised level once it has disagreed with DB for
  // DEBOUNCE_MS consecutive cycles; any agreement restarts the count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      DB    <= 1'b0;
      RISE  <= 1'b0;
      FALL  <= 1'b0;
    end else begin
      sync1 <= BTN;
      sync2 <= sync1;
      RISE  <= 1'b0;
      FALL  <= 1'b0;
      if (sync2 == DB) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt  <= '0;
        DB   <= sync2;
        RISE <= sync2;
        FALL <= ~sync2;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/button_gesture_ctrl.sv
// Single-button UI controller: classifies debounced presses into short,
// double and long gestures and steps a 4-mode LED sequencer.
// Ports: CLK, RST (sync, active high), BTN (raw button, 1 = pressed),
//        LED (registered drive), MODE (0 OFF, 1 ON, 2 SLOW, 3 FAST),
//        EVT_SHORT / EVT_DOUBLE / EVT_LONG (one-cycle gesture pulses).
module button_gesture_ctrl
  import gesture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS   = DEF_DEBOUNCE_MS,
  parameter int unsigned LONG_MS       = DEF_LONG_MS,
  parameter int unsigned DOUBLE_GAP_MS = DEF_DOUBLE_GAP_MS,
  parameter int unsigned SLOW_HALF_MS  = DEF_SLOW_HALF_MS,
  parameter int unsigned FAST_HALF_MS  = DEF_FAST_HALF_MS
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN,
  output logic       LED,
  output logic [1:0] MODE,
  output logic       EVT_SHORT,
  output logic       EVT_DOUBLE,
  output logic       EVT_LONG
);

  localparam int unsigned CNT_W = cnt_width(max_u(LONG_MS, DOUBLE_GAP_MS));
  localparam int unsigned PH_W  = cnt_width(max_u(SLOW_HALF_MS, FAST_HALF_MS));
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP_MS - 1);
  localparam logic [PH_W-1:0]  SLOW_LAST = PH_W'(SLOW_HALF_MS - 1);
  localparam logic [PH_W-1:0]  FAST_LAST = PH_W'(FAST_HALF_MS - 1);

  logic db;
  logic rise;
  logic fall;

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_debounce (
    .CLK  (CLK),
    .RST  (RST),
    .BTN  (BTN),
    .DB   (db),
    .RISE (rise),
    .FALL (fall)
  );

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] cnt_inc;
  logic             evt_short_n;
  logic             evt_double_n;
  logic             evt_long_n;
  mode_t            mode;
  mode_t            prev_mode;
  logic [PH_W-1:0]  phase;
  logic [PH_W-1:0]  half_last;

  // Saturating increment of the gesture counter.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  // Gesture FSM state, counter and registered event pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      EVT_SHORT  <= 1'b0;
      EVT_DOUBLE <= 1'b0;
      EVT_LONG   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      EVT_SHORT  <= evt_short_n;
      EVT_DOUBLE <= evt_double_n;
      EVT_LONG   <= evt_long_n;
    end
  end

  // Thresholds compare the incremented count so each pulse lands exactly
  // LONG_MS / DOUBLE_GAP_MS cycles after the triggering strobe; a threshold
  // is checked before fall so it wins a same-cycle release.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt_inc;
    evt_short_n  = 1'b0;
    evt_double_n = 1'b0;
    evt_long_n   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (rise) state_n = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (cnt_inc == LONG_LAST) begin
          evt_long_n = 1'b1;
          state_n    = ST_HELD;
        end else if (fall) begin
          cnt_n   = '0;
          state_n = ST_WAIT2;
        end
      end
      ST_WAIT2: begin
        if (rise) begin
          cnt_n   = '0;
          state_n = ST_PRESS2;
        end else if (cnt_inc == GAP_LAST) begin
          evt_short_n = 1'b1;
          state_n     = ST_IDLE;
        end
      end
      ST_PRESS2: begin
        if (cnt_inc == LONG_LAST) begin
          evt_long_n = 1'b1;
          state_n    = ST_HELD;
        end else if (fall) begin
          evt_double_n = 1'b1;
          state_n      = ST_IDLE;
        end
      end
      ST_HELD: begin
        // Level test also absorbs a release whose strobe coincided with
        // the long-press threshold.
        cnt_n = '0;
        if (!db) state_n = ST_IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  // Mode sequencer, stepped one cycle after each event.
  always_ff @(posedge CLK) begin
    if (RST) mode <= MODE_OFF;
    else     mode <= next_mode(mode, EVT_SHORT, EVT_DOUBLE, EVT_LONG);
  end

  assign MODE      = mode;
  assign half_last = (mode == MODE_SLOW) ? SLOW_LAST : FAST_LAST;

  // LED generator; a mode change into a blink mode restarts the phase high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      LED       <= 1'b0;
      phase     <= '0;
      prev_mode <= MODE_OFF;
    end else begin
      prev_mode <= mode;
      unique case (mode)
        MODE_OFF: begin
          LED   <= 1'b0;
          phase <= '0;
        end
        MODE_ON: begin
          LED   <= 1'b1;
          phase <= '0;
        end
        default: begin
          if (mode != prev_mode) begin
            LED   <= 1'b1;
            phase <= '0;
          end else if (phase == half_last) begin
            LED   <= ~LED;
            phase <= '0;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_gesture_ctrl.sv
// Directed self-checking bench for button_gesture_ctrl at default timing.
module tb_button_gesture_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic       led;
  logic [1:0] mode;
  logic       evt_short;
  logic       evt_double;
  logic       evt_long;

  int checks   = 0;
  int failures = 0;

  int cyc = 0;
  int n_short = 0, n_double = 0, n_long = 0, n_multi = 0;
  int t_short = -1, t_short_prev = -1, t_double = -1, t_long = -1;

  button_gesture_ctrl dut (
    .CLK        (clk),
    .RST        (rst),
    .BTN        (btn),
    .LED        (led),
    .MODE       (mode),
    .EVT_SHORT  (evt_short),
    .EVT_DOUBLE (evt_double),
    .EVT_LONG   (evt_long)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: counts pulses and records the cycle of the latest one.
  always @(negedge clk) begin
    if (evt_short === 1'b1) begin
      t_short_prev = t_short;
      t_short      = cyc;
      n_short++;
    end
    if (evt_double === 1'b1) begin
      t_double = cyc;
      n_double++;
    end
    if (evt_long === 1'b1) begin
      t_long = cyc;
      n_long++;
    end
    if ((int'(evt_short === 1'b1) + int'(evt_double === 1'b1) +
         int'(evt_long === 1'b1)) > 1)
      n_multi++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = 1'b0;
    repeat (3) tick();
    checks++;
    if (led !== 1'b0) begin
      failures++; $display("FAIL reset_led act=%b exp=0", led);
    end
    checks++;
    if (mode !== 2'd0) begin
      failures++; $display("FAIL reset_mode act=%0d exp=0", mode);
    end
    checks++;
    if ({evt_short, evt_double, evt_long} !== 3'b000) begin
      failures++; $display("FAIL reset_evt act=%b exp=000", {evt_short, evt_double, evt_long});
    end
    rst = 1'b0;
    tick();
  endtask

  // Short press OFF -> ON: EVT_SHORT 300 cycles after fall (22 + 200 + 300).
  task automatic test_short_press();
    int p, s0;
    s0 = n_short;
    p = cyc;
    btn = 1'b1;
    wait_to(p + 200);
    btn = 1'b0;
    wait_to(p + 522);
    checks++;
    if (evt_short !== 1'b1) begin
      failures++; $display("FAIL short_evt act=%b exp=1", evt_short);
    end
    checks++;
    if (mode !== 2'd0) begin
      failures++; $display("FAIL short_mode_pre act=%0d exp=0", mode);
    end
    wait_to(p + 523);
    checks++;
    if (mode !== 2'd1) begin
      failures++; $display("FAIL short_mode act=%0d exp=1", mode);
    end
    checks++;
    if (led !== 1'b0) begin
      failures++; $display("FAIL short_led_pre act=%b exp=0", led);
    end
    wait_to(p + 524);
    checks++;
    if (led !== 1'b1) begin
      failures++; $display("FAIL short_led act=%b exp=1", led);
    end
    wait_to(p + 900);
    checks++;
    if (n_short - s0 !== 1 || t_short !== p + 522) begin
      failures++;
      $display("FAIL short_count act=%0d@%0d exp=1@%0d", n_short - s0, t_short, p + 522);
    end
  endtask

  // Long press from ON: EVT_LONG 1000 cycles after rise, nothing at release.
  task automatic test_long_press();
    int p, s0, l0;
    s0 = n_short;
    l0 = n_long;
    p = cyc;
    btn = 1'b1;
    wait_to(p + 1021);
    checks++;
    if (evt_long !== 1'b0) begin
      failures++; $display("FAIL long_early act=%b exp=0", evt_long);
    end
    wait_to(p + 1022);
    checks++;
    if (evt_long !== 1'b1) begin
      failures++; $display("FAIL long_evt act=%b exp=1", evt_long);
    end
    wait_to(p + 1023);
    checks++;
    if (mode !== 2'd0) begin
      failures++; $display("FAIL long_mode act=%0d exp=0", mode);
    end
    wait_to(p + 1200);
    btn = 1'b0;
    wait_to(p + 1700);
    checks++;
    if (n_long - l0 !== 1 || n_short - s0 !== 0) begin
      failures++;
      $display("FAIL long_count act=long%0d/short%0d exp=long1/short0", n_long - l0, n_short - s0);
    end
  endtask

  // Double click (100 press, 150 gap, 100 press); LED blink from entry.
  task automatic test_double_click(input logic [1:0] exp_mode, input int half);
    int p, s0, d0, l0, e;
    s0 = n_short;
    d0 = n_double;
    l0 = n_long;
    p = cyc;
    btn = 1'b1;
    wait_to(p + 100);
    btn = 1'b0;
    wait_to(p + 250);
    btn = 1'b1;
    wait_to(p + 350);
    btn = 1'b0;
    wait_to(p + 373);
    checks++;
    if (evt_double !== 1'b1) begin
      failures++; $display("FAIL double_evt act=%b exp=1", evt_double);
    end
    wait_to(p + 374);
    checks++;
    if (mode !== exp_mode) begin
      failures++; $display("FAIL double_mode act=%0d exp=%0d", mode, exp_mode);
    end
    e = p + 375;
    wait_to(e);
    checks++;
    if (led !== 1'b1) begin
      failures++; $display("FAIL double_led_entry act=%b exp=1", led);
    end
    wait_to(e + half - 1);
    checks++;
    if (led !== 1'b1) begin
      failures++; $display("FAIL double_led_hi act=%b exp=1", led);
    end
    wait_to(e + half);
    checks++;
    if (led !== 1'b0) begin
      failures++; $display("FAIL double_led_toggle act=%b exp=0", led);
    end
    wait_to(e + 2 * half - 1);
    checks++;
    if (led !== 1'b0) begin
      failures++; $display("FAIL double_led_lo act=%b exp=0", led);
    end
    wait_to(e + 2 * half);
    checks++;
    if (led !== 1'b1) begin
      failures++; $display("FAIL double_led_toggle2 act=%b exp=1", led);
    end
    checks++;
    if (n_double - d0 !== 1 || n_short - s0 !== 0 || n_long - l0 !== 0) begin
      failures++;
      $display("FAIL double_count act=d%0d/s%0d/l%0d exp=d1/s0/l0",
               n_double - d0, n_short - s0, n_long - l0);
    end
  endtask

  // Chatter with a 5-cycle period for 50 cycles never settles for 20 cycles.
  task automatic test_bounce();
    int s0, d0, l0;
    s0 = n_short;
    d0 = n_double;
    l0 = n_long;
    for (int i = 0; i < 10; i++) begin
      btn = 1'b1;
      repeat (3) tick();
      btn = 1'b0;
      repeat (2) tick();
    end
    btn = 1'b0;
    repeat (400) tick();
    checks++;
    if (mode !== 2'd3) begin
      failures++; $display("FAIL bounce_mode act=%0d exp=3", mode);
    end
    checks++;
    if (n_short - s0 + n_double - d0 + n_long - l0 !== 0) begin
      failures++;
      $display("FAIL bounce_events act=%0d exp=0", n_short - s0 + n_double - d0 + n_long - l0);
    end
  endtask

  // 350-cycle gap: first press becomes a short, second starts a new gesture.
  task automatic test_gap_expiry();
    int p, s0, d0;
    s0 = n_short;
    d0 = n_double;
    p = cyc;
    btn = 1'b1;
    wait_to(p + 100);
    btn = 1'b0;
    wait_to(p + 422);
    checks++;
    if (evt_short !== 1'b1) begin
      failures++; $display("FAIL gap_short1 act=%b exp=1", evt_short);
    end
    wait_to(p + 423);
    checks++;
    if (mode !== 2'd0) begin
      failures++; $display("FAIL gap_mode1 act=%0d exp=0", mode);
    end
    wait_to(p + 450);
    btn = 1'b1;
    wait_to(p + 550);
    btn = 1'b0;
    wait_to(p + 872);
    checks++;
    if (evt_short !== 1'b1) begin
      failures++; $display("FAIL gap_short2 act=%b exp=1", evt_short);
    end
    wait_to(p + 873);
    checks++;
    if (mode !== 2'd1) begin
      failures++; $display("FAIL gap_mode2 act=%0d exp=1", mode);
    end
    wait_to(p + 1000);
    checks++;
    if (n_short - s0 !== 2 || n_double - d0 !== 0 ||
        t_short_prev !== p + 422 || t_short !== p + 872) begin
      failures++;
      $display("FAIL gap_count act=s%0d/d%0d@%0d,%0d exp=s2/d0@%0d,%0d",
               n_short - s0, n_double - d0, t_short_prev, t_short, p + 422, p + 872);
    end
  endtask

  // Fall strobe arrives on the threshold cycle: long wins, release absorbed.
  task automatic test_threshold_fall();
    int p, q, s0, l0;
    s0 = n_short;
    l0 = n_long;
    p = cyc;
    btn = 1'b1;
    wait_to(p + 999);
    btn = 1'b0;
    wait_to(p + 1022);
    checks++;
    if (evt_long !== 1'b1) begin
      failures++; $display("FAIL thr_long act=%b exp=1", evt_long);
    end
    wait_to(p + 1023);
    checks++;
    if (mode !== 2'd0) begin
      failures++; $display("FAIL thr_mode act=%0d exp=0", mode);
    end
    wait_to(p + 1500);
    checks++;
    if (n_long - l0 !== 1 || n_short - s0 !== 0) begin
      failures++;
      $display("FAIL thr_count act=l%0d/s%0d exp=l1/s0", n_long - l0, n_short - s0);
    end
    q = cyc;
    btn = 1'b1;
    wait_to(q + 200);
    btn = 1'b0;
    wait_to(q + 523);
    checks++;
    if (mode !== 2'd1 || t_short !== q + 522) begin
      failures++;
      $display("FAIL thr_recover act=%0d@%0d exp=1@%0d", mode, t_short, q + 522);
    end
    wait_to(q + 700);
  endtask

  // Reset 600 cycles into a hold; the still-held button is a fresh press.
  task automatic test_reset_mid_hold();
    int p, s0, l0;
    s0 = n_short;
    l0 = n_long;
    p = cyc;
    btn = 1'b1;
    wait_to(p + 600);
    checks++;
    if (mode !== 2'd1) begin
      failures++; $display("FAIL rsthold_pre_mode act=%0d exp=1", mode);
    end
    rst = 1'b1;
    wait_to(p + 601);
    rst = 1'b0;
    checks++;
    if (led !== 1'b0 || mode !== 2'd0 || {evt_short, evt_double, evt_long} !== 3'b000) begin
      failures++;
      $display("FAIL rsthold_outputs act=led%b/mode%0d/evt%b exp=led0/mode0/evt000",
               led, mode, {evt_short, evt_double, evt_long});
    end
    wait_to(p + 800);
    btn = 1'b0;
    wait_to(p + 1122);
    checks++;
    if (evt_short !== 1'b1) begin
      failures++; $display("FAIL rsthold_short act=%b exp=1", evt_short);
    end
    wait_to(p + 1123);
    checks++;
    if (mode !== 2'd1) begin
      failures++; $display("FAIL rsthold_mode act=%0d exp=1", mode);
    end
    wait_to(p + 1300);
    checks++;
    if (n_long - l0 !== 0 || n_short - s0 !== 1) begin
      failures++;
      $display("FAIL rsthold_count act=l%0d/s%0d exp=l0/s1", n_long - l0, n_short - s0);
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_press();
    test_double_click(2'd2, 500);
    test_double_click(2'd3, 125);
    test_bounce();
    test_gap_expiry();
    test_threshold_fall();
    test_reset_mid_hold();
    checks++;
    if (n_multi !== 0) begin
      failures++; $display("FAIL one_event_per_cycle act=%0d exp=0", n_multi);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
